// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback collector.
// Optional feature macro used by the collector files: WB_FLUSH_EN.
package wb_pkg;

    localparam int ROB_QUEUE_BITS = 5;
    localparam int VAL_W          = 16;
    localparam int LOC_W          = 18;

    // loc[17:16] == LOC_REG marks a register destination; loc[15:0] is the register address.
    localparam logic [1:0] LOC_REG = 2'b00;

    typedef struct packed {
        logic [ROB_QUEUE_BITS-1:0] uid;
        logic [VAL_W-1:0]          val;
        logic [LOC_W-1:0]          loc;
    } wb_entry_t;

    typedef enum logic [0:0] {
        WB_ARB  = 1'b0,
        WB_HOLD = 1'b1
    } wb_state_t;

    // Increment an index modulo n (n need not be a power of two).
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: per-unit result FIFO with combinational head read.
// Optional feature macro: WB_FLUSH_EN (adds a synchronous flush input).
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
`ifdef WB_FLUSH_EN
    input  logic   flush,
`endif
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Next pointers/count/storage; requests are re-qualified so a stray push/pop cannot corrupt state.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
`ifdef WB_FLUSH_EN
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
`endif
    end

    // Pointer and occupancy registers; reset drops all buffered entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_collector.sv
// wb_collector: buffers functional-unit results per unit and drains them
// round-robin to the writeback port over a valid/ready handshake.
// Optional feature macro: WB_FLUSH_EN (adds the synchronous flush input).
//
// state   | meaning
// WB_ARB  | grant recomputed each cycle from rr_ptr; pop on handshake
// WB_HOLD | output stalled; grant frozen at lock_q until wb_ready
module wb_collector
    import wb_pkg::*;
#(
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
`ifdef WB_FLUSH_EN
    input  logic                             flush,
`endif
    input  logic [NUM_FU-1:0]                fu_valid,
    input  logic [NUM_FU*ROB_QUEUE_BITS-1:0] fu_uid,
    input  logic [NUM_FU*VAL_W-1:0]          fu_val,
    input  logic [NUM_FU*LOC_W-1:0]          fu_loc,
    output logic [NUM_FU-1:0]                fu_ready,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [ROB_QUEUE_BITS-1:0]        wb_uid,
    output logic [VAL_W-1:0]                 wb_val,
    output logic [LOC_W-1:0]                 wb_loc,
    output logic                             wb_overflow
);

    localparam int FU_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0] full, empty, push, pop;
    wb_entry_t         dout [NUM_FU];
    wb_entry_t         head;
    wb_state_t         state_q, state_d;
    logic [FU_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [FU_W-1:0]   lock_q, lock_d;
    logic [FU_W-1:0]   arb_grant, grant;
    logic              overflow_q, overflow_d;
    logic              fire;

    assign fu_ready = ~full;
    assign push     = fu_valid & fu_ready;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
        wb_entry_t din;
        assign din = {fu_uid[g*ROB_QUEUE_BITS +: ROB_QUEUE_BITS],
                      fu_val[g*VAL_W +: VAL_W],
                      fu_loc[g*LOC_W +: LOC_W]};
        wb_fifo #(.DEPTH(DEPTH), .entry_t(wb_entry_t)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
`ifdef WB_FLUSH_EN
            .flush (flush),
`endif
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din),
            .dout  (dout[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        logic found;
        int   idx;
        found     = 1'b0;
        idx       = 0;
        arb_grant = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_FU;
            if (!found && !empty[idx]) begin
                found     = 1'b1;
                arb_grant = FU_W'(idx);
            end
        end
    end

    assign grant    = (state_q == WB_HOLD) ? lock_q : arb_grant;
    assign wb_valid = |(~empty);
    assign fire     = wb_valid & wb_ready;
    assign head     = dout[grant];
    assign wb_uid   = wb_valid ? head.uid : '0;
    assign wb_val   = wb_valid ? head.val : '0;
    assign wb_loc   = wb_valid ? head.loc : '0;

    assign wb_overflow = overflow_q;

    // Arbiter next state, pop selection and sticky overflow.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        pop        = '0;
        overflow_d = overflow_q | (|(fu_valid & ~fu_ready));
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i] = fire && (grant == FU_W'(i));
        end
        case (state_q)
            WB_ARB: begin
                if (fire) begin
                    rr_ptr_d = FU_W'(wrap_inc(int'(grant), NUM_FU));
                end else if (wb_valid) begin
                    lock_d  = grant;
                    state_d = WB_HOLD;
                end
            end
            WB_HOLD: begin
                if (fire) begin
                    rr_ptr_d = FU_W'(wrap_inc(int'(lock_q), NUM_FU));
                    state_d  = WB_ARB;
                end
            end
            default: state_d = WB_ARB;
        endcase
`ifdef WB_FLUSH_EN
        if (flush) begin
            state_d  = WB_ARB;
            rr_ptr_d = '0;
        end
`endif
    end

    // Arbiter and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WB_ARB;
            rr_ptr_q   <= '0;
            lock_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_wb_collector.sv
// tb_wb_collector: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the writeback collector.
module tb_wb_collector;
    import wb_pkg::*;

    localparam int NUM_FU = 4;
    localparam int DEPTH  = 4;
    localparam int RB     = ROB_QUEUE_BITS;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic [NUM_FU-1:0]      fu_valid = '0;
    logic [NUM_FU*RB-1:0]   fu_uid = '0;
    logic [NUM_FU*16-1:0]   fu_val = '0;
    logic [NUM_FU*18-1:0]   fu_loc = '0;
    logic [NUM_FU-1:0]      fu_ready;
    logic                   wb_valid;
    logic                   wb_ready = 1'b0;
    logic [RB-1:0]          wb_uid;
    logic [15:0]            wb_val;
    logic [17:0]            wb_loc;
    logic                   wb_overflow;
    wb_entry_t              act;

    int passed = 0;
    int total  = 0;

    // Reference model: one queue per unit, a round-robin start index and the
    // unit whose result is currently presented but not yet accepted.
    wb_entry_t mq [NUM_FU][$];
    int        rr_m   = 0;
    int        held_m = -1;
    bit        ovf_m  = 1'b0;

    always #5 clk = ~clk;

    assign act = {wb_uid, wb_val, wb_loc};

    wb_collector #(.NUM_FU(NUM_FU), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef WB_FLUSH_EN
        .flush       (flush),
`endif
        .fu_valid    (fu_valid),
        .fu_uid      (fu_uid),
        .fu_val      (fu_val),
        .fu_loc      (fu_loc),
        .fu_ready    (fu_ready),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_uid      (wb_uid),
        .wb_val      (wb_val),
        .wb_loc      (wb_loc),
        .wb_overflow (wb_overflow)
    );

    function automatic wb_entry_t mk(input logic [RB-1:0] u, input logic [15:0] v, input logic [17:0] l);
        wb_entry_t e;
        e.uid = u;
        e.val = v;
        e.loc = l;
        return e;
    endfunction

    function automatic int model_grant();
        if (held_m >= 0) return held_m;
        for (int i = 0; i < NUM_FU; i++) begin
            int k;
            k = (rr_m + i) % NUM_FU;
            if (mq[k].size() > 0) return k;
        end
        return -1;
    endfunction

    function automatic logic [NUM_FU-1:0] model_ready();
        logic [NUM_FU-1:0] r;
        for (int i = 0; i < NUM_FU; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        rr_m   = 0;
        held_m = -1;
        ovf_m  = 1'b0;
    endtask

    task automatic set_fu(input int i, input logic [RB-1:0] u, input logic [15:0] v, input logic [17:0] l);
        fu_valid[i]        = 1'b1;
        fu_uid[i*RB +: RB] = u;
        fu_val[i*16 +: 16] = v;
        fu_loc[i*18 +: 18] = l;
    endtask

    // Advance the model by the current inputs, then the DUT by one clock edge.
    task automatic tick();
        int                g;
        logic [NUM_FU-1:0] room;
        g    = model_grant();
        room = model_ready();
        if (g >= 0) begin
            if (wb_ready) begin
                void'(mq[g].pop_front());
                rr_m   = (g + 1) % NUM_FU;
                held_m = -1;
            end else begin
                held_m = g;
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i]) begin
                if (room[i]) mq[i].push_back(mk(fu_uid[i*RB +: RB], fu_val[i*16 +: 16], fu_loc[i*18 +: 18]));
                else ovf_m = 1'b1;
            end
        end
`ifdef WB_FLUSH_EN
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            rr_m   = 0;
            held_m = -1;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        bit busy;
        n = 0;
        fu_valid = '0;
        wb_ready = 1'b1;
        busy = (model_grant() >= 0);
        while (busy && n < 100) begin
            tick();
            n++;
            busy = (model_grant() >= 0);
        end
        total++;
        if (busy) $display("FAIL %s_drain model still holds entries after %0d cycles", name, n);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); else passed++;
        total++; if (fu_ready !== 4'hF) $display("FAIL reset_fu_ready got=%h exp=f", fu_ready); else passed++;
        total++; if (wb_overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", wb_overflow); else passed++;
        total++; if (act !== '0) $display("FAIL reset_payload got=%h exp=0", act); else passed++;
        model_reset();
        #6;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_four();
        wb_entry_t exp;
        wb_ready = 1'b1;
        for (int k = 0; k < NUM_FU; k++) set_fu(k, RB'(10 + k), 16'hA000 + 16'(k), 18'h00100 + 18'(k));
        #2;
        total++; if (wb_valid !== 1'b0) $display("FAIL four_no_bypass got=%b exp=0", wb_valid); else passed++;
        tick();
        fu_valid = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            #2;
            exp = mk(RB'(10 + k), 16'hA000 + 16'(k), 18'h00100 + 18'(k));
            total++;
            if (wb_valid !== 1'b1 || act !== exp) $display("FAIL four_order_%0d got=%b/%h exp=1/%h", k, wb_valid, act, exp);
            else passed++;
            tick();
        end
        #2;
        total++; if (wb_valid !== 1'b0) $display("FAIL four_idle got=%b exp=0", wb_valid); else passed++;
        // FU3 and FU0 together: FU0 must win, showing the pointer wrapped to 0.
        set_fu(3, RB'(30), 16'h3333, 18'h00033);
        set_fu(0, RB'(31), 16'h0000, 18'h00030);
        tick();
        fu_valid = '0;
        #2;
        total++; if (wb_uid !== RB'(31)) $display("FAIL four_rr_wrap got=%0d exp=31", wb_uid); else passed++;
        tick();
        #2;
        total++; if (wb_uid !== RB'(30)) $display("FAIL four_rr_second got=%0d exp=30", wb_uid); else passed++;
        tick();
    endtask

    task automatic test_hold();
        wb_entry_t held;
        held = mk(RB'(7), 16'hBEEF, 18'h00009);
        wb_ready = 1'b0;
        set_fu(2, held.uid, held.val, held.loc);
        tick();
        fu_valid = '0;
        for (int k = 0; k < 5; k++) begin
            fu_valid = '0;
            if (k < 3) set_fu(0, RB'(16 + k), 16'h0100 + 16'(k), 18'h00020 + 18'(k));
            #2;
            total++;
            if (wb_valid !== 1'b1 || act !== held) $display("FAIL hold_stable_%0d got=%b/%h exp=1/%h", k, wb_valid, act, held);
            else passed++;
            tick();
        end
        fu_valid = '0;
        wb_ready = 1'b1;
        #2;
        total++; if (act !== held) $display("FAIL hold_release got=%h exp=%h", act, held); else passed++;
        tick();
        for (int k = 0; k < 3; k++) begin
            #2;
            total++;
            if (wb_valid !== 1'b1 || wb_uid !== RB'(16 + k)) $display("FAIL hold_fu0_%0d got=%b/%0d exp=1/%0d", k, wb_valid, wb_uid, 16 + k);
            else passed++;
            tick();
        end
        #2;
        total++; if (wb_valid !== 1'b0) $display("FAIL hold_idle got=%b exp=0", wb_valid); else passed++;
    endtask

    task automatic test_single();
        wb_entry_t exp;
        exp = mk(RB'(3), 16'h1234, 18'h00005);
        wb_ready = 1'b1;
        set_fu(1, exp.uid, exp.val, exp.loc);
        #2;
        total++; if (wb_valid !== 1'b0) $display("FAIL single_latency got=%b exp=0", wb_valid); else passed++;
        tick();
        fu_valid = '0;
        #2;
        total++;
        if (wb_valid !== 1'b1 || act !== exp) $display("FAIL single_payload got=%b/%h exp=1/%h", wb_valid, act, exp);
        else passed++;
        tick();
        #2;
        total++; if (wb_valid !== 1'b0) $display("FAIL single_idle got=%b exp=0", wb_valid); else passed++;
    endtask

    task automatic test_overflow();
        int cnt;
        wb_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            fu_valid = '0;
            #2;
            total++; if (fu_ready[0] !== 1'b1) $display("FAIL ovf_ready_%0d got=%b exp=1", k, fu_ready[0]); else passed++;
            set_fu(0, RB'(20 + k), 16'h0200 + 16'(k), 18'h00040 + 18'(k));
            tick();
        end
        fu_valid = '0;
        #2;
        total++; if (fu_ready !== 4'b1110) $display("FAIL ovf_full got=%b exp=1110", fu_ready); else passed++;
        total++; if (wb_overflow !== 1'b0) $display("FAIL ovf_early got=%b exp=0", wb_overflow); else passed++;
        set_fu(0, RB'(24), 16'h0299, 18'h00049);
        tick();
        fu_valid = '0;
        #2;
        total++; if (wb_overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", wb_overflow); else passed++;
        wb_ready = 1'b1;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            #2;
            if (wb_valid === 1'b1) begin
                total++;
                if (wb_uid !== RB'(20 + cnt)) $display("FAIL ovf_drain_%0d got=%0d exp=%0d", cnt, wb_uid, 20 + cnt);
                else passed++;
                cnt++;
            end
            tick();
        end
        total++; if (cnt != DEPTH) $display("FAIL ovf_count got=%0d exp=%0d", cnt, DEPTH); else passed++;
        total++; if (wb_overflow !== 1'b1) $display("FAIL ovf_stays got=%b exp=1", wb_overflow); else passed++;
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b0;
        set_fu(0, RB'(1), 16'h1111, 18'h00001);
        set_fu(1, RB'(2), 16'h2222, 18'h00002);
        set_fu(3, RB'(4), 16'h4444, 18'h00004);
        tick();
        fu_valid = '0;
        #2;
        total++; if (wb_valid !== 1'b1) $display("FAIL rstmid_pre got=%b exp=1", wb_valid); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (wb_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", wb_valid); else passed++;
        total++; if (fu_ready !== 4'hF) $display("FAIL rstmid_ready got=%h exp=f", fu_ready); else passed++;
        total++; if (wb_overflow !== 1'b0) $display("FAIL rstmid_ovf got=%b exp=0", wb_overflow); else passed++;
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #2;
            total++; if (wb_valid !== 1'b0) $display("FAIL rstmid_stale_%0d got=%b exp=0", n, wb_valid); else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        int        g;
        wb_entry_t exp;
        for (int n = 0; n < 600; n++) begin
            fu_valid = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if ($urandom_range(0, 99) < 30) set_fu(i, RB'($urandom), 16'($urandom), 18'($urandom));
            end
            wb_ready = ($urandom_range(0, 99) < 65);
            #2;
            g = model_grant();
            total++;
            if (wb_valid !== (g >= 0)) $display("FAIL rand_valid_%0d got=%b exp=%b", n, wb_valid, g >= 0);
            else passed++;
            if (g >= 0) begin
                exp = mq[g][0];
                total++;
                if (act !== exp) $display("FAIL rand_payload_%0d got=%h exp=%h (fu%0d)", n, act, exp, g);
                else passed++;
            end
            total++;
            if (fu_ready !== model_ready()) $display("FAIL rand_ready_%0d got=%b exp=%b", n, fu_ready, model_ready());
            else passed++;
            total++;
            if (wb_overflow !== ovf_m) $display("FAIL rand_ovf_%0d got=%b exp=%b", n, wb_overflow, ovf_m);
            else passed++;
            tick();
        end
        drain("rand");
    endtask

`ifdef WB_FLUSH_EN
    task automatic test_flush();
        wb_ready = 1'b0;
        set_fu(0, RB'(5), 16'h5555, 18'h00005);
        set_fu(1, RB'(6), 16'h6666, 18'h00006);
        tick();
        fu_valid = '0;
        set_fu(2, RB'(8), 16'h8888, 18'h00008);
        wb_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fu_valid = '0;
        #2;
        total++; if (wb_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", wb_valid); else passed++;
        total++; if (fu_ready !== 4'hF) $display("FAIL flush_ready got=%h exp=f", fu_ready); else passed++;
        set_fu(1, RB'(9), 16'h9999, 18'h00019);
        set_fu(0, RB'(10), 16'hAAAA, 18'h0001A);
        tick();
        fu_valid = '0;
        #2;
        total++; if (wb_uid !== RB'(10)) $display("FAIL flush_rr got=%0d exp=10", wb_uid); else passed++;
        drain("flush");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_four();
        test_hold();
        test_single();
        test_overflow();
        test_reset_mid();
        test_random();
`ifdef WB_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
